// File: rtl/line_feeder.sv
// line_feeder: streams frame-memory pixels to the neighbourhood top, preload lines then one line per o_intr rise.
// Latency: first o_data_valid 3 cycles after i_start is sampled; one beat per cycle while i_data_ready=1.
// Backpressure: 2-entry output FIFO; reads issue only while occupancy + in-flight - pop < 2.
// Optional: define LINE_FEEDER_PAD_EN to append PAD_LINES interrupt-gated zero lines after the image.
`timescale 1ns/1ps
module line_feeder #(
  parameter int IMG_WIDTH     = 512,
  parameter int IMG_HEIGHT    = 512,
  parameter int PRELOAD_LINES = 4,
  parameter int PAD_LINES     = 2,
  parameter int ADDR_W        = 18
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_data_valid,
  output logic [7:0]        o_data,
  input  logic              i_data_ready,
  input  logic              i_intr
);
  localparam int BURST_MAX = PRELOAD_LINES * IMG_WIDTH;
  localparam int BW        = $clog2(BURST_MAX + 1);
  localparam int LW        = $clog2(IMG_HEIGHT + 2);
`ifdef LINE_FEEDER_PAD_EN
  localparam int PW        = $clog2(PAD_LINES + 2);
`endif

  // Reject parameter sets that cannot describe a valid frame.
  if ((IMG_HEIGHT < PRELOAD_LINES) || (PAD_LINES < 0) ||
      ((longint'(1) << ADDR_W) < longint'(IMG_WIDTH) * longint'(IMG_HEIGHT))) begin : g_bad_params
    $error("line_feeder: inconsistent IMG_HEIGHT/PRELOAD_LINES/PAD_LINES/ADDR_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_WAIT,
    S_LINE,
`ifdef LINE_FEEDER_PAD_EN
    S_PAD_WAIT,
    S_PAD,
`endif
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     req_q, req_d;      // pixels of the current burst still to request
  logic [LW-1:0]     lines_q, lines_d;  // image lines launched so far in this frame
`ifdef LINE_FEEDER_PAD_EN
  logic [PW-1:0]     pads_q, pads_d;    // pad lines launched so far in this frame
`endif
  logic [2:0]        pend_q, pend_d;
  logic              intr_q;
  logic              infl_q, infl_pad_q;
  logic [7:0]        fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;

  logic       pop, push, issue, pad_burst, in_burst, room, drained, req_end;
  logic       more_lines, more_pads, rise, launch;
  logic [2:0] occ_after_pop;
  logic [7:0] push_dat;

  // Handshake, read-issue gating and burst-end detection.
  always_comb begin
    pop           = (cnt_q != 2'd0) && i_data_ready;
    push          = infl_q;
    push_dat      = infl_pad_q ? 8'h00 : i_mem_data;
    occ_after_pop = 3'(cnt_q) + 3'(infl_q) - 3'(pop);
    room          = occ_after_pop < 3'd2;
`ifdef LINE_FEEDER_PAD_EN
    pad_burst     = (state_q == S_PAD);
    more_pads     = pads_q < PW'(PAD_LINES);
`else
    pad_burst     = 1'b0;
    more_pads     = 1'b0;
`endif
    in_burst      = (state_q == S_PRELOAD) || (state_q == S_LINE) || pad_burst;
    issue         = in_burst && (req_q != '0) && room;
    // The next burst may launch on the same edge as the last request, so lines join without a bubble.
    req_end       = in_burst && ((req_q == '0) || (issue && (req_q == BW'(1))));
    drained       = (req_q == '0) && (occ_after_pop == 3'd0);
    more_lines    = lines_q < LW'(IMG_HEIGHT);
    rise          = i_intr && !intr_q;
    cnt_d         = cnt_q + 2'(push) - 2'(pop);
  end

  // Frame sequencing: preload, interrupt-gated lines (and pads), drain, done.
  always_comb begin
    state_d = state_q;
    addr_d  = o_mem_rd_en ? addr_q + ADDR_W'(1) : addr_q;
    req_d   = issue ? req_q - BW'(1) : req_q;
    lines_d = lines_q;
`ifdef LINE_FEEDER_PAD_EN
    pads_d  = pads_q;
`endif
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_PRELOAD;
          addr_d  = '0;
          req_d   = BW'(BURST_MAX);
          lines_d = LW'(PRELOAD_LINES);
`ifdef LINE_FEEDER_PAD_EN
          pads_d  = '0;
`endif
        end
      end
      S_PRELOAD,
`ifdef LINE_FEEDER_PAD_EN
      S_PAD,
`endif
      S_LINE: begin
        if (req_end) begin
          if (more_lines || more_pads) begin
            if (pend_q != 3'd0) launch = 1'b1;
`ifdef LINE_FEEDER_PAD_EN
            else if (!more_lines) state_d = S_PAD_WAIT;
`endif
            else state_d = S_WAIT;
          end else if (drained) begin
            state_d = S_DONE;
          end
        end
      end
      S_WAIT: launch = (pend_q != 3'd0);
`ifdef LINE_FEEDER_PAD_EN
      S_PAD_WAIT: launch = (pend_q != 3'd0);
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      req_d = BW'(IMG_WIDTH);
      if (more_lines) begin
        state_d = S_LINE;
        lines_d = lines_q + LW'(1);
      end
`ifdef LINE_FEEDER_PAD_EN
      else begin
        state_d = S_PAD;
        pads_d  = pads_q + PW'(1);
      end
`endif
    end
  end

  // Pending line requests: rises in, launches out, saturating at 7; cleared between frames.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE) begin
      pend_d = 3'd0;
    end else if (state_q != S_DONE) begin
      case ({rise, launch})
        2'b10:   pend_d = (pend_q == 3'd7) ? pend_q : pend_q + 3'd1;
        2'b01:   pend_d = pend_q - 3'd1;
        default: pend_d = pend_q;
      endcase
    end
  end

  assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done       = (state_q == S_DONE);
  assign o_mem_rd_en  = issue && !pad_burst;
  assign o_mem_addr   = addr_q;
  assign o_data_valid = (cnt_q != 2'd0);
  assign o_data       = fifo_q[rd_ptr_q];

  // Control state and frame counters.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      req_q   <= '0;
      lines_q <= '0;
`ifdef LINE_FEEDER_PAD_EN
      pads_q  <= '0;
`endif
      pend_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      lines_q <= lines_d;
`ifdef LINE_FEEDER_PAD_EN
      pads_q  <= pads_d;
`endif
      pend_q  <= pend_d;
    end
  end

  // Output FIFO storage, in-flight read tracking and interrupt edge register.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      fifo_q[0]  <= 8'h00;
      fifo_q[1]  <= 8'h00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      infl_q     <= 1'b0;
      infl_pad_q <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      if (push) fifo_q[wr_ptr_q] <= push_dat;
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      cnt_q      <= cnt_d;
      infl_q     <= issue;
      infl_pad_q <= issue && pad_burst;
      intr_q     <= i_intr;
    end
  end
endmodule

// File: tb/tb_line_feeder.sv
// tb_line_feeder: randomized-ready scoreboard bench for line_feeder on an 8x6 frame.
// Expected beats are queued by a frame-level model when start/interrupts are issued; a monitor pops on each accepted beat.
// Pad lines are expected only when LINE_FEEDER_PAD_EN is defined.
`timescale 1ns/1ps
module tb_line_feeder;
  localparam int W = 8, H = 6, PRE = 4, PADL = 2, AW = 18;
`ifdef LINE_FEEDER_PAD_EN
  localparam int PADS = PADL;
`else
  localparam int PADS = 0;
`endif
  localparam int TOTAL = (H + PADS) * W;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, intr = 1'b0, ready = 1'b1;
  logic [7:0]    mem_data = 8'h00;
  logic          o_busy, o_done, o_mem_rd_en, o_data_valid;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    o_data;

  int tests = 0, fails = 0, cyc = 0;
  int beats = 0, done_seen = 0, last_beat_cyc = -10;
  int rdy_mode = 0;
  int m_lines = 0, m_pads = 0, m_addr = 0;
  int beats_base = 0, done_base = 0;
  logic [7:0] exp_q[$];

  line_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PRELOAD_LINES(PRE), .PAD_LINES(PADL), .ADDR_W(AW)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start), .o_busy(o_busy), .o_done(o_done),
    .o_mem_rd_en(o_mem_rd_en), .o_mem_addr(o_mem_addr), .i_mem_data(mem_data),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(ready), .i_intr(intr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Synchronous frame memory, mem[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) if (o_mem_rd_en) mem_data <= o_mem_addr[7:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level reference model: which bytes the next request should yield.
  function automatic bit all_pushed();
    return (m_lines == H) && (m_pads == PADS);
  endfunction

  function automatic void push_line(input bit zero);
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(zero ? 8'h00 : 8'(m_addr));
      if (!zero) m_addr++;
    end
  endfunction

  function automatic void model_start();
    m_addr = 0; m_lines = PRE; m_pads = 0;
    beats_base = beats; done_base = done_seen;
    for (int l = 0; l < PRE; l++) push_line(1'b0);
  endfunction

  function automatic int model_rise();
    if (done_seen > done_base) return 0;
    if (m_lines < H) begin push_line(1'b0); m_lines++; return 1; end
    if (m_pads < PADS) begin push_line(1'b1); m_pads++; return 1; end
    return 0;
  endfunction

  // Ready pattern: 0 = always ready, 1 = alternating, otherwise random.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: ready = 1'b1;
      1: ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on every accepted beat, checks hold-while-stalled and done timing.
  initial begin
    logic [7:0] held_dat;
    bit held_vld;
    held_vld = 0; held_dat = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 0;
      end else begin
        if (held_vld) check("hold_stable", 32'({o_data_valid, o_data}), 32'({1'b1, held_dat}));
        held_vld = o_data_valid && !ready;
        held_dat = o_data;
        if (o_data_valid && ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL extra_beat: got data %0h, expected no beat (cycle %0d)", o_data, cyc);
          end else begin
            check("beat_data", 32'(o_data), 32'(exp_q.pop_front()));
          end
          beats++;
          last_beat_cyc = cyc;
        end
        if (o_done) begin
          check("done_timing", 32'({exp_q.size() == 0, all_pushed(), cyc == last_beat_cyc + 1, o_busy}), 32'(4'b1110));
          done_seen++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int waited);
    waited = 0;
    do begin @(negedge clk); waited++; end while (!o_data_valid && waited < bound);
    check("valid_seen", 32'(o_data_valid), 32'(1));
  endtask

  task automatic run_check(input int n, input string name);
    int gaps = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (!(o_data_valid && ready)) gaps++;
    end
    check(name, 32'(gaps), 32'(0));
  endtask

  task automatic intr_line(input string name);
    int n, w;
    intr = 1'b1;
    n = model_rise();
    if (n != 0) begin wait_valid(12, w); run_check(W, name); end
    tick(1); intr = 1'b0; tick(40);
  endtask

  task automatic intr_plain();
    int n;
    intr = 1'b1; n = model_rise(); tick(3); intr = 1'b0; tick(40);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_seen == done_base && k < 400) begin @(negedge clk); k++; end
    tick(3);
    check(name, 32'(done_seen - done_base), 32'(1));
    check({name, "_beats"}, 32'(beats - beats_base), 32'(TOTAL));
    check({name, "_idle"}, 32'({o_busy, o_data_valid, o_mem_rd_en}), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    tick(3);
    check("reset_outputs", 32'({o_busy, o_done, o_mem_rd_en, o_mem_addr, o_data_valid, o_data}), 32'(0));
    rst_n = 1'b1; tick(2);

    // Preload then full frame, ready held high
    model_start(); pulse_start();
    wait_valid(10, w);
    check("first_valid_within_3", 32'(w <= 3), 32'(1));
    run_check(PRE * W, "preload_run");
    tick(20);
    check("preload_wait_state", 32'({o_data_valid, o_mem_rd_en, o_busy}), 32'(3'b001));
    check("preload_beats", 32'(beats - beats_base), 32'(PRE * W));
    for (int i = 0; i < 4; i++) intr_line("line_run");
    wait_done("frame1_done");

    // Backpressure: alternating ready for the preload, random ready afterwards
    rdy_mode = 1;
    model_start(); pulse_start();
    for (int k = 0; k < 300 && (beats - beats_base) < PRE * W; k++) @(negedge clk);
    tick(10);
    check("bp_preload_beats", 32'(beats - beats_base), 32'(PRE * W));
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) intr_plain();
    wait_done("bp_frame_done");
    rdy_mode = 0; tick(3);

    // Early interrupts during preload: two lines follow with no gap
    model_start(); pulse_start();
    fork
      begin
        int n;
        tick(4); intr = 1'b1; n = model_rise(); tick(2); intr = 1'b0;
        tick(2); intr = 1'b1; n = model_rise(); tick(2); intr = 1'b0;
      end
      begin
        int w2;
        wait_valid(10, w2);
        run_check(PRE * W + 2 * W, "early_intr_run");
      end
    join
    tick(5);
    for (int i = 0; i < 2; i++) intr_line("early_pad_run");
    wait_done("early_frame_done");

    // Start pulse while busy is ignored
    model_start(); pulse_start();
    wait_valid(10, w);
    run_check(PRE * W, "busy_preload_run");
    tick(5); pulse_start(); tick(10);
    check("busy_start_ignored", 32'({o_data_valid, o_mem_rd_en, o_busy}), 32'(3'b001));
    for (int i = 0; i < 4; i++) intr_line("busy_line_run");
    wait_done("busy_frame_done");

    // Reset in the middle of a line, then restart from address 0
    model_start(); pulse_start();
    wait_valid(10, w);
    run_check(PRE * W, "rst_preload_run");
    tick(5);
    intr = 1'b1;
    w = model_rise();
    wait_valid(12, w);
    tick(3);
    rst_n = 1'b0; #1;
    check("reset_mid_line", 32'({o_busy, o_done, o_mem_rd_en, o_mem_addr, o_data_valid, o_data}), 32'(0));
    exp_q.delete();
    intr = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    model_start(); pulse_start();
    wait_valid(10, w);
    check("restart_first_beat", 32'(o_data), 32'(0));
    run_check(PRE * W, "restart_preload_run");
    tick(5);
    for (int i = 0; i < 4; i++) intr_line("restart_line_run");
    wait_done("restart_frame_done");

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
